// File: rtl/issue2_fetch_alloc.sv
// -----------------------------------------------------------------------------
// issue2_fetch_alloc
//   Dual-issue fetch allocator. Buffers 32-bit instructions from the prefetch
//   buffer in an in-order circular queue and, each cycle, presents the head
//   entry to the primary ID stage (pi) and, when the two head entries carry
//   no intra-pair hazard, the second entry to the secondary ID stage (i2).
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush_i               : drop all queued entries and the fetch word offered
//   dual_issue_en_i       : 0 forces single issue
//   fregfile_disable_i    : FP register file disabled (to mini-decoders)
//   fetch_valid_i/_ready_o: fetch handshake (ready = room for two entries)
//   fetch_addr_i/rdata_i  : 64-bit fetch word and its byte address
//   pi_*                  : head0 towards primary ID (pi_ready_i pops)
//   i2_*                  : head1, issued together with head0
//   pair_cnt_o/single_cnt_o: saturating dispatch statistics
// -----------------------------------------------------------------------------

// Mini-decoder: extracts register usage of one instruction for hazard checks.
// Register addresses are 6 bits; bit 5 selects the FP register file.
module issue2_fetch_alloc_mini_decode #(
  parameter int unsigned FPU   = 0,
  parameter int unsigned Zfinx = 0
) (
  input  logic [31:0] instr_i,
  input  logic        fregfile_disable_i,
  output logic        regfile_alu_we_dec_o,
  output logic        regfile_mem_we_dec_o,
  output logic [5:0]  regfile_waddr_o,
  output logic [5:0]  raddr_a_o,
  output logic [5:0]  raddr_b_o,
  output logic [5:0]  raddr_c_o,
  output logic        rega_used_o,
  output logic        regb_used_o,
  output logic        regc_used_o,
  output logic        addr_ra_is_also_dst_o,
  output logic        pi_legal_o,
  output logic        i2_legal_o
);
  logic       fp_en_s;
  logic       fr_s;
  logic [6:0] opcode_s;

  assign opcode_s = instr_i[6:0];
  assign fp_en_s  = (FPU != 0) && !fregfile_disable_i;
  // With Zfinx, FP operands live in the integer register file.
  assign fr_s     = (Zfinx == 0) ? 1'b1 : 1'b0;

  // Opcode-driven register usage; control flow and system ops are never paired.
  always_comb begin
    regfile_alu_we_dec_o  = 1'b0;
    regfile_mem_we_dec_o  = 1'b0;
    regfile_waddr_o       = {1'b0, instr_i[11:7]};
    raddr_a_o             = {1'b0, instr_i[19:15]};
    raddr_b_o             = {1'b0, instr_i[24:20]};
    raddr_c_o             = {1'b0, instr_i[31:27]};
    rega_used_o           = 1'b0;
    regb_used_o           = 1'b0;
    regc_used_o           = 1'b0;
    addr_ra_is_also_dst_o = 1'b0;
    pi_legal_o            = 1'b0;
    i2_legal_o            = 1'b0;
    case (opcode_s)
      7'h13: begin  // OP-IMM
        regfile_alu_we_dec_o = 1'b1;
        rega_used_o = 1'b1;
        pi_legal_o = 1'b1;
        i2_legal_o = 1'b1;
      end
      7'h33: begin  // OP / MUL-DIV
        regfile_alu_we_dec_o = 1'b1;
        rega_used_o = 1'b1;
        regb_used_o = 1'b1;
        if ((instr_i[31:25] == 7'h00) || (instr_i[31:25] == 7'h20)) begin
          pi_legal_o = 1'b1;
          i2_legal_o = 1'b1;
        end else if (instr_i[31:25] == 7'h01) begin
          // multi-cycle unit only reachable from the primary slot
          pi_legal_o = 1'b1;
        end else begin
          pi_legal_o = 1'b0;
        end
      end
      7'h37, 7'h17: begin  // LUI, AUIPC
        regfile_alu_we_dec_o = 1'b1;
        pi_legal_o = 1'b1;
        i2_legal_o = 1'b1;
      end
      7'h03: begin  // LOAD
        regfile_mem_we_dec_o = 1'b1;
        rega_used_o = 1'b1;
        pi_legal_o = 1'b1;
        i2_legal_o = 1'b1;
      end
      7'h0B: begin  // post-increment load: rs1 is written back as well
        regfile_mem_we_dec_o  = 1'b1;
        rega_used_o           = 1'b1;
        addr_ra_is_also_dst_o = 1'b1;
        pi_legal_o = 1'b1;
        i2_legal_o = 1'b1;
      end
      7'h23: begin  // STORE
        rega_used_o = 1'b1;
        regb_used_o = 1'b1;
        pi_legal_o = 1'b1;
        i2_legal_o = 1'b1;
      end
      7'h63: begin  // BRANCH
        rega_used_o = 1'b1;
        regb_used_o = 1'b1;
      end
      7'h6F: begin  // JAL
        regfile_alu_we_dec_o = 1'b1;
      end
      7'h67: begin  // JALR
        regfile_alu_we_dec_o = 1'b1;
        rega_used_o = 1'b1;
      end
      7'h07: begin  // FLW
        if (fp_en_s) begin
          regfile_mem_we_dec_o = 1'b1;
          regfile_waddr_o = {fr_s, instr_i[11:7]};
          rega_used_o = 1'b1;
          pi_legal_o = 1'b1;
          i2_legal_o = 1'b1;
        end else begin
          pi_legal_o = 1'b0;
        end
      end
      7'h27: begin  // FSW
        if (fp_en_s) begin
          rega_used_o = 1'b1;
          regb_used_o = 1'b1;
          raddr_b_o = {fr_s, instr_i[24:20]};
          pi_legal_o = 1'b1;
          i2_legal_o = 1'b1;
        end else begin
          pi_legal_o = 1'b0;
        end
      end
      7'h43, 7'h47, 7'h4B, 7'h4F: begin  // fused multiply-add family
        if (fp_en_s) begin
          regfile_alu_we_dec_o = 1'b1;
          regfile_waddr_o = {fr_s, instr_i[11:7]};
          raddr_a_o = {fr_s, instr_i[19:15]};
          raddr_b_o = {fr_s, instr_i[24:20]};
          raddr_c_o = {fr_s, instr_i[31:27]};
          rega_used_o = 1'b1;
          regb_used_o = 1'b1;
          regc_used_o = 1'b1;
        end else begin
          regc_used_o = 1'b0;
        end
      end
      default: begin
        pi_legal_o = 1'b0;
        i2_legal_o = 1'b0;
      end
    endcase
  end
endmodule

module issue2_fetch_alloc #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned FPU   = 0,
  parameter int unsigned Zfinx = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        dual_issue_en_i,
  input  logic        fregfile_disable_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_addr_i,
  input  logic [63:0] fetch_rdata_i,
  output logic        pi_valid_o,
  input  logic        pi_ready_i,
  output logic [31:0] pi_instr_o,
  output logic [31:0] pi_addr_o,
  output logic        i2_valid_o,
  output logic [31:0] i2_instr_o,
  output logic [31:0] i2_addr_o,
  output logic [31:0] pair_cnt_o,
  output logic [31:0] single_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   addr_q  [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr1_s, wr_ptr1_s;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pair_cnt_q, pair_cnt_d, single_cnt_q, single_cnt_d;
  logic          push_s, pop_s, pi_valid_s, i2_valid_s;
  logic [1:0]    push_n_s, pop_n_s;

  logic          alu_we0_s, mem_we0_s, alu_we1_s, mem_we1_s;
  logic [5:0]    wa0_s, ra0_s, rb0_s, rc0_s, wa1_s, ra1_s, rb1_s, rc1_s;
  logic          ua0_s, ub0_s, uc0_s, ua1_s, ub1_s, uc1_s;
  logic          radst0_s, radst1_s, pil0_s, i2l0_s, pil1_s, i2l1_s;
  logic          w0_s, w1_s, raw_s, waw_s, radst_hz_s, ld_hz_s, hazard_s;

  assign rd_ptr1_s = rd_ptr_q + PW'(1);
  assign wr_ptr1_s = wr_ptr_q + PW'(1);

  issue2_fetch_alloc_mini_decode #(.FPU(FPU), .Zfinx(Zfinx)) u_dec0 (
    .instr_i(instr_q[rd_ptr_q]), .fregfile_disable_i(fregfile_disable_i),
    .regfile_alu_we_dec_o(alu_we0_s), .regfile_mem_we_dec_o(mem_we0_s),
    .regfile_waddr_o(wa0_s), .raddr_a_o(ra0_s), .raddr_b_o(rb0_s), .raddr_c_o(rc0_s),
    .rega_used_o(ua0_s), .regb_used_o(ub0_s), .regc_used_o(uc0_s),
    .addr_ra_is_also_dst_o(radst0_s), .pi_legal_o(pil0_s), .i2_legal_o(i2l0_s)
  );

  issue2_fetch_alloc_mini_decode #(.FPU(FPU), .Zfinx(Zfinx)) u_dec1 (
    .instr_i(instr_q[rd_ptr1_s]), .fregfile_disable_i(fregfile_disable_i),
    .regfile_alu_we_dec_o(alu_we1_s), .regfile_mem_we_dec_o(mem_we1_s),
    .regfile_waddr_o(wa1_s), .raddr_a_o(ra1_s), .raddr_b_o(rb1_s), .raddr_c_o(rc1_s),
    .rega_used_o(ua1_s), .regb_used_o(ub1_s), .regc_used_o(uc1_s),
    .addr_ra_is_also_dst_o(radst1_s), .pi_legal_o(pil1_s), .i2_legal_o(i2l1_s)
  );

  // Intra-pair hazards: RAW, WAW, write-back of rs1 by head0, two loads.
  assign w0_s       = alu_we0_s | mem_we0_s;
  assign w1_s       = alu_we1_s | mem_we1_s;
  assign raw_s      = w0_s && (wa0_s != 6'd0) &&
                      ((ua1_s && (ra1_s == wa0_s)) || (ub1_s && (rb1_s == wa0_s)) ||
                       (uc1_s && (rc1_s == wa0_s)));
  assign waw_s      = w0_s && w1_s && (wa1_s == wa0_s);
  assign radst_hz_s = radst0_s && (ra0_s != 6'd0) &&
                      ((ua1_s && (ra1_s == ra0_s)) || (ub1_s && (rb1_s == ra0_s)) ||
                       (uc1_s && (rc1_s == ra0_s)) || (w1_s && (wa1_s == ra0_s)));
  assign ld_hz_s    = mem_we0_s && mem_we1_s;
  assign hazard_s   = raw_s || waw_s || radst_hz_s || ld_hz_s;

  // Ready only looks at the registered count so it never depends on a pop.
  assign fetch_ready_o = (count_q <= CW'(DEPTH - 2));
  assign push_s        = fetch_valid_i && fetch_ready_o && !flush_i;
  assign push_n_s      = push_s ? (fetch_addr_i[2] ? 2'd1 : 2'd2) : 2'd0;

  assign pi_valid_s = (count_q != CW'(0)) && !flush_i;
  assign i2_valid_s = pi_valid_s && (count_q >= CW'(2)) && dual_issue_en_i &&
                      pil0_s && i2l1_s && !hazard_s;
  assign pop_s      = pi_valid_s && pi_ready_i;
  assign pop_n_s    = pop_s ? (i2_valid_s ? 2'd2 : 2'd1) : 2'd0;

  assign pi_valid_o   = pi_valid_s;
  assign pi_instr_o   = instr_q[rd_ptr_q];
  assign pi_addr_o    = addr_q[rd_ptr_q];
  assign i2_valid_o   = i2_valid_s;
  assign i2_instr_o   = instr_q[rd_ptr1_s];
  assign i2_addr_o    = addr_q[rd_ptr1_s];
  assign pair_cnt_o   = pair_cnt_q;
  assign single_cnt_o = single_cnt_q;

  // Next-state for pointers, occupancy and saturating dispatch counters.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    pair_cnt_d   = pair_cnt_q;
    single_cnt_d = single_cnt_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = CW'(0);
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop_n_s);
      wr_ptr_d = wr_ptr_q + PW'(push_n_s);
      count_d  = count_q + CW'(push_n_s) - CW'(pop_n_s);
    end
    if (pop_s && i2_valid_s && (pair_cnt_q != 32'hFFFF_FFFF)) begin
      pair_cnt_d = pair_cnt_q + 32'd1;
    end else if (pop_s && !i2_valid_s && (single_cnt_q != 32'hFFFF_FFFF)) begin
      single_cnt_d = single_cnt_q + 32'd1;
    end else begin
      pair_cnt_d = pair_cnt_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pair_cnt_q   <= 32'd0;
      single_cnt_q <= 32'd0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pair_cnt_q   <= pair_cnt_d;
      single_cnt_q <= single_cnt_d;
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      if (fetch_addr_i[2]) begin
        instr_q[wr_ptr_q] <= fetch_rdata_i[63:32];
        addr_q[wr_ptr_q]  <= fetch_addr_i;
      end else begin
        instr_q[wr_ptr_q]  <= fetch_rdata_i[31:0];
        addr_q[wr_ptr_q]   <= fetch_addr_i;
        instr_q[wr_ptr1_s] <= fetch_rdata_i[63:32];
        addr_q[wr_ptr1_s]  <= fetch_addr_i + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_issue2_fetch_alloc.sv
// -----------------------------------------------------------------------------
// tb_issue2_fetch_alloc
//   Directed bench for issue2_fetch_alloc (DEPTH=4): pairing, RAW and load
//   hazards, single-entry pushes, back-pressure, flush and push/pop overlap.
// -----------------------------------------------------------------------------
module tb_issue2_fetch_alloc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        dual_issue_en_i = 1'b0;
  logic        fregfile_disable_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_addr_i = 32'd0;
  logic [63:0] fetch_rdata_i = 64'd0;
  logic        pi_valid_o;
  logic        pi_ready_i = 1'b0;
  logic [31:0] pi_instr_o, pi_addr_o;
  logic        i2_valid_o;
  logic [31:0] i2_instr_o, i2_addr_o;
  logic [31:0] pair_cnt_o, single_cnt_o;

  int tests = 0;
  int fails = 0;

  issue2_fetch_alloc #(.DEPTH(4), .FPU(0), .Zfinx(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .dual_issue_en_i(dual_issue_en_i),
    .fregfile_disable_i(fregfile_disable_i), .fetch_valid_i(fetch_valid_i),
    .fetch_ready_o(fetch_ready_o), .fetch_addr_i(fetch_addr_i), .fetch_rdata_i(fetch_rdata_i),
    .pi_valid_o(pi_valid_o), .pi_ready_i(pi_ready_i), .pi_instr_o(pi_instr_o),
    .pi_addr_o(pi_addr_o), .i2_valid_o(i2_valid_o), .i2_instr_o(i2_instr_o),
    .i2_addr_o(i2_addr_o), .pair_cnt_o(pair_cnt_o), .single_cnt_o(single_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] addr, input logic [63:0] data);
    fetch_valid_i = 1'b1;
    fetch_addr_i  = addr;
    fetch_rdata_i = data;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_pi_valid", pi_valid_o, 32'd0);
    chk("rst_i2_valid", i2_valid_o, 32'd0);
    chk("rst_ready", fetch_ready_o, 32'd1);
    chk("rst_pair", pair_cnt_o, 32'd0);
    chk("rst_single", single_cnt_o, 32'd0);
    rst_n = 1'b1;
    dual_issue_en_i = 1'b1;
    pi_ready_i = 1'b1;

    // independent addi pair dispatches together
    offer(32'h100, {32'h00200193, 32'h00100113});
    tick(); fetch_valid_i = 1'b0;
    chk("A_pi_valid", pi_valid_o, 32'd1);
    chk("A_pi_addr", pi_addr_o, 32'h100);
    chk("A_pi_instr", pi_instr_o, 32'h00100113);
    chk("A_i2_valid", i2_valid_o, 32'd1);
    chk("A_i2_addr", i2_addr_o, 32'h104);
    chk("A_i2_instr", i2_instr_o, 32'h00200193);
    tick();
    chk("A_pair", pair_cnt_o, 32'd1);
    chk("A_empty", pi_valid_o, 32'd0);
    chk("A_single", single_cnt_o, 32'd0);

    // RAW: addi x5 then add x6,x5,x5 -> two singles
    offer(32'h200, {32'h00528333, 32'h00100293});
    tick(); fetch_valid_i = 1'b0;
    chk("B_pi_instr0", pi_instr_o, 32'h00100293);
    chk("B_i2_valid0", i2_valid_o, 32'd0);
    tick();
    chk("B_pi_instr1", pi_instr_o, 32'h00528333);
    chk("B_pi_addr1", pi_addr_o, 32'h204);
    chk("B_i2_valid1", i2_valid_o, 32'd0);
    chk("B_single1", single_cnt_o, 32'd1);
    tick();
    chk("B_single2", single_cnt_o, 32'd2);
    chk("B_empty", pi_valid_o, 32'd0);

    // two loads never pair
    offer(32'h300, {32'h0040A403, 32'h0000A383});
    tick(); fetch_valid_i = 1'b0;
    chk("C_pi_addr0", pi_addr_o, 32'h300);
    chk("C_i2_valid0", i2_valid_o, 32'd0);
    tick();
    chk("C_pi_addr1", pi_addr_o, 32'h304);
    chk("C_i2_valid1", i2_valid_o, 32'd0);
    tick();
    chk("C_single", single_cnt_o, 32'd4);
    chk("C_pair", pair_cnt_o, 32'd1);

    // single-entry push from upper half, then fill to 3 with pi stalled
    pi_ready_i = 1'b0;
    offer(32'h204, {32'h00000013, 32'hFFFFFFFF});
    tick(); fetch_valid_i = 1'b0;
    chk("D_pi_addr", pi_addr_o, 32'h204);
    chk("D_pi_instr", pi_instr_o, 32'h00000013);
    chk("D_i2_valid1", i2_valid_o, 32'd0);
    chk("D_ready1", fetch_ready_o, 32'd1);
    offer(32'h208, {32'h00528333, 32'h00100113});
    tick(); fetch_valid_i = 1'b0;
    chk("D_ready3", fetch_ready_o, 32'd0);
    chk("D_pi_stable", pi_addr_o, 32'h204);
    chk("D_i2_valid3", i2_valid_o, 32'd1);
    chk("D_i2_addr3", i2_addr_o, 32'h208);
    chk("D_i2_instr3", i2_instr_o, 32'h00100113);
    dual_issue_en_i = 1'b0; #1;
    chk("D_i2_dual_off", i2_valid_o, 32'd0);
    dual_issue_en_i = 1'b1;
    tick();
    chk("D_pi_held", pi_addr_o, 32'h204);
    chk("D_single_held", single_cnt_o, 32'd4);

    // flush with 3 entries and a fetch word offered
    flush_i = 1'b1;
    offer(32'h400, {32'h00200193, 32'h00100113});
    #1;
    chk("F_pi_valid_during", pi_valid_o, 32'd0);
    tick(); flush_i = 1'b0; fetch_valid_i = 1'b0;
    chk("F_pi_valid_after", pi_valid_o, 32'd0);
    chk("F_ready_after", fetch_ready_o, 32'd1);
    chk("F_single_kept", single_cnt_o, 32'd4);
    chk("F_pair_kept", pair_cnt_o, 32'd1);

    // flush while a fetch word would otherwise be accepted
    offer(32'h504, {32'h00000013, 32'h00000000});
    tick(); fetch_valid_i = 1'b0;
    chk("G_pi_addr", pi_addr_o, 32'h504);
    flush_i = 1'b1;
    offer(32'h600, {32'h00200193, 32'h00100113});
    tick(); flush_i = 1'b0; fetch_valid_i = 1'b0;
    chk("G_empty1", pi_valid_o, 32'd0);
    tick();
    chk("G_dropped", pi_valid_o, 32'd0);

    // pointers realigned after flush
    pi_ready_i = 1'b1;
    offer(32'h700, {32'h00200193, 32'h00100113});
    tick(); fetch_valid_i = 1'b0;
    chk("E_pi_addr", pi_addr_o, 32'h700);
    chk("E_i2_addr", i2_addr_o, 32'h704);
    chk("E_i2_valid", i2_valid_o, 32'd1);
    tick();
    chk("E_pair", pair_cnt_o, 32'd2);

    // single issue forced, with push and pop in the same cycle
    dual_issue_en_i = 1'b0;
    offer(32'h800, {32'h00000013, 32'h00000013});
    tick();
    offer(32'h908, {32'h00000013, 32'h00000013});
    chk("H_pi_addr0", pi_addr_o, 32'h800);
    chk("H_i2_valid0", i2_valid_o, 32'd0);
    chk("H_ready0", fetch_ready_o, 32'd1);
    tick(); fetch_valid_i = 1'b0;
    chk("H_pi_addr1", pi_addr_o, 32'h804);
    chk("H_single1", single_cnt_o, 32'd5);
    chk("H_ready1", fetch_ready_o, 32'd0);
    tick();
    chk("H_pi_addr2", pi_addr_o, 32'h908);
    tick();
    chk("H_pi_addr3", pi_addr_o, 32'h90C);
    tick();
    chk("H_single_end", single_cnt_o, 32'd8);
    chk("H_empty", pi_valid_o, 32'd0);
    chk("H_pair_end", pair_cnt_o, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
